// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Contents:
//   REG_ADDR_W, DATA_W  register address / data widths
//   WB_BUF_DEPTH        default depth of the deferred long-latency result buffer
//   md_result_t         one buffered long-latency result (destination + data)
package mips_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int WB_BUF_DEPTH = 2;
  localparam int NUM_REGS     = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     data;
  } md_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset (empties the FIFO)
//   Push, PushData  write one entry at the rising edge (ignored when Full)
//   Pop             remove the head entry at the rising edge (ignored when Empty)
//   PopData         current head entry, valid whenever Empty=0
//   Full, Empty     occupancy flags
// Storage is not reset; only pointers and the occupancy count are.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Push,
  input  logic [WIDTH-1:0] PushData,
  input  logic             Pop,
  output logic [WIDTH-1:0] PopData,
  output logic             Full,
  output logic             Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign Full    = (count == FULL_CNT);
  assign Empty   = (count == '0);
  assign do_push = Push && !Full;
  assign do_pop  = Pop && !Empty;
  assign PopData = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= PushData;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback path and buffered long-latency (mult/div) results, and keeps a
// busy scoreboard that stalls decode on hazards against pending results.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   WbRegWr, WbRW, WbBusW    pipeline writeback request (always has priority)
//   IssueLong, IssueRW       decode issues a long-latency op to IssueRW
//   SrcRA, SrcRB             decode source registers
//   MdValid, MdRW, MdData    long-latency result offered to the buffer
//   MdReady                  buffer accepts a result this cycle
//   Stall                    decode must hold this cycle
//   RegWr, RW, BusW          register-file write port
//
// Handshake: a result transfers on a rising edge where MdValid=1 and
// MdReady=1; the producer holds MdValid/MdRW/MdData stable until then.
// MdReady depends only on buffer occupancy (and reset), never on MdValid.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = WB_BUF_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  WbRegWr,
  input  logic [REG_ADDR_W-1:0] WbRW,
  input  logic [DATA_W-1:0]     WbBusW,
  input  logic                  IssueLong,
  input  logic [REG_ADDR_W-1:0] IssueRW,
  input  logic [REG_ADDR_W-1:0] SrcRA,
  input  logic [REG_ADDR_W-1:0] SrcRB,
  input  logic                  MdValid,
  input  logic [REG_ADDR_W-1:0] MdRW,
  input  logic [DATA_W-1:0]     MdData,
  output logic                  MdReady,
  output logic                  Stall,
  output logic                  RegWr,
  output logic [REG_ADDR_W-1:0] RW,
  output logic [DATA_W-1:0]     BusW
);

  md_result_t           push_entry;
  md_result_t           head;
  logic                 buf_full;
  logic                 buf_empty;
  logic                 buf_push;
  logic                 buf_pop;
  logic                 wb_claims;
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  busy_next;

  assign push_entry = '{rw: MdRW, data: MdData};
  assign MdReady    = !Rst && !buf_full;
  // Results for r0 complete the handshake but are never stored.
  assign buf_push   = MdValid && MdReady && (MdRW != '0);
  assign wb_claims  = WbRegWr && (WbRW != '0);
  assign buf_pop    = !Rst && !wb_claims && !buf_empty;

  sync_fifo #(
    .WIDTH ($bits(md_result_t)),
    .DEPTH (DEPTH)
  ) u_result_buf (
    .Clk      (Clk),
    .Rst      (Rst),
    .Push     (buf_push),
    .PushData (push_entry),
    .Pop      (buf_pop),
    .PopData  (head),
    .Full     (buf_full),
    .Empty    (buf_empty)
  );

  // Write port mux: writeback first, then buffer head, else idle zeros.
  always_comb begin
    RegWr = 1'b0;
    RW    = '0;
    BusW  = '0;
    if (!Rst) begin
      if (wb_claims) begin
        RegWr = 1'b1;
        RW    = WbRW;
        BusW  = WbBusW;
      end else if (!buf_empty) begin
        RegWr = 1'b1;
        RW    = head.rw;
        BusW  = head.data;
      end
    end
  end

  assign Stall = !Rst && (busy[SrcRA] || busy[SrcRB] || (IssueLong && busy[IssueRW]));

  // Clear on pop is applied before set so a same-register collision leaves
  // the bit set for the newly issued op.
  always_comb begin
    busy_next = busy;
    if (buf_pop) busy_next[head.rw] = 1'b0;
    if (IssueLong && !Stall && (IssueRW != '0)) busy_next[IssueRW] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        Clk;
  logic        Rst;
  logic        WbRegWr;
  logic [4:0]  WbRW;
  logic [31:0] WbBusW;
  logic        IssueLong;
  logic [4:0]  IssueRW;
  logic [4:0]  SrcRA;
  logic [4:0]  SrcRB;
  logic        MdValid;
  logic [4:0]  MdRW;
  logic [31:0] MdData;
  logic        MdReady;
  logic        Stall;
  logic        RegWr;
  logic [4:0]  RW;
  logic [31:0] BusW;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected drain order of buffered results: {rw, data}.
  logic [36:0] exp_q[$];

  wb_port_arbiter #(.DEPTH(2)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .WbRegWr   (WbRegWr),
    .WbRW      (WbRW),
    .WbBusW    (WbBusW),
    .IssueLong (IssueLong),
    .IssueRW   (IssueRW),
    .SrcRA     (SrcRA),
    .SrcRB     (SrcRB),
    .MdValid   (MdValid),
    .MdRW      (MdRW),
    .MdData    (MdData),
    .MdReady   (MdReady),
    .Stall     (Stall),
    .RegWr     (RegWr),
    .RW        (RW),
    .BusW      (BusW)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_port(input string tag, input logic wr, input logic [4:0] rw, input logic [31:0] d);
    chk({tag, ".RegWr"}, {31'd0, RegWr}, {31'd0, wr});
    chk({tag, ".RW"},    {27'd0, RW},    {27'd0, rw});
    chk({tag, ".BusW"},  BusW,           d);
  endtask

  task automatic wb(input logic en, input logic [4:0] rw, input logic [31:0] d);
    WbRegWr = en;
    WbRW    = rw;
    WbBusW  = d;
  endtask

  task automatic md(input logic v, input logic [4:0] rw, input logic [31:0] d);
    MdValid = v;
    MdRW    = rw;
    MdData  = d;
  endtask

  // Scoreboard: the head of exp_q must be what the write port shows now.
  task automatic chk_drain(input string tag);
    logic [36:0] e;
    e = exp_q.pop_front();
    chk_port(tag, 1'b1, e[36:32], e[31:0]);
  endtask

  initial begin
    Rst = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    md(1'b0, 5'd0, 32'd0);
    IssueLong = 1'b0;
    IssueRW   = 5'd0;
    SrcRA     = 5'd0;
    SrcRB     = 5'd0;
    tick();
    tick();

    // Reset forces outputs low even with a WB request present.
    wb(1'b1, 5'd5, 32'h1234_5678);
    settle();
    chk("rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("rst_mdready", {31'd0, MdReady}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    Rst = 1'b0;
    settle();
    chk_port("idle", 1'b0, 5'd0, 32'd0);
    chk("idle_mdready", {31'd0, MdReady}, 32'd1);
    chk("idle_stall", {31'd0, Stall}, 32'd0);

    // WB only: same-cycle pass-through.
    wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    settle();
    chk_port("wb_only", 1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Collision: set busy[7], then result for r7 arrives while WB writes r3.
    IssueLong = 1'b1;
    IssueRW   = 5'd7;
    settle();
    chk("coll_issue_stall", {31'd0, Stall}, 32'd0);
    tick();
    IssueLong = 1'b0;
    IssueRW   = 5'd0;
    SrcRA     = 5'd7;
    wb(1'b1, 5'd3, 32'h0000_0033);
    md(1'b1, 5'd7, 32'h0000_0011);
    settle();
    chk("coll_stall_a", {31'd0, Stall}, 32'd1);
    chk_port("coll_a", 1'b1, 5'd3, 32'h33);
    tick();
    md(1'b0, 5'd0, 32'd0);
    settle();
    chk_port("coll_b", 1'b1, 5'd3, 32'h33);
    chk("coll_stall_b", {31'd0, Stall}, 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    settle();
    chk_port("coll_c", 1'b1, 5'd7, 32'h11);
    chk("coll_stall_c", {31'd0, Stall}, 32'd1);
    tick();
    settle();
    chk_port("coll_d", 1'b0, 5'd0, 32'd0);
    chk("coll_stall_d", {31'd0, Stall}, 32'd0);
    SrcRA = 5'd0;

    // Full buffer: three back-to-back results while WB keeps the port.
    wb(1'b1, 5'd2, 32'h0000_0022);
    md(1'b1, 5'd10, 32'hA0);
    settle();
    chk("full_rdy1", {31'd0, MdReady}, 32'd1);
    exp_q.push_back({5'd10, 32'hA0});
    tick();
    md(1'b1, 5'd11, 32'hB0);
    settle();
    chk("full_rdy2", {31'd0, MdReady}, 32'd1);
    exp_q.push_back({5'd11, 32'hB0});
    tick();
    md(1'b1, 5'd12, 32'hC0);
    settle();
    chk("full_rdy3", {31'd0, MdReady}, 32'd0);
    chk_port("full_wb", 1'b1, 5'd2, 32'h22);
    tick();
    settle();
    chk("full_held", {31'd0, MdReady}, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    settle();
    // Full with a pop pending: still not ready this cycle.
    chk("full_poprdy", {31'd0, MdReady}, 32'd0);
    chk_drain("drain0");
    tick();
    settle();
    chk("full_rdy_after", {31'd0, MdReady}, 32'd1);
    exp_q.push_back({5'd12, 32'hC0});
    chk_drain("drain1");
    tick();
    md(1'b0, 5'd0, 32'd0);
    settle();
    chk_drain("drain2");
    chk("drain_qempty", exp_q.size(), 32'd0);
    tick();
    settle();
    chk_port("drain_done", 1'b0, 5'd0, 32'd0);

    // Scoreboard: r9 busy stalls readers and a WAW issue until popped.
    IssueLong = 1'b1;
    IssueRW   = 5'd9;
    settle();
    chk("sb_issue", {31'd0, Stall}, 32'd0);
    tick();
    settle();
    chk("sb_waw", {31'd0, Stall}, 32'd1);
    IssueLong = 1'b0;
    IssueRW   = 5'd0;
    SrcRA     = 5'd9;
    settle();
    chk("sb_raw", {31'd0, Stall}, 32'd1);
    tick();
    md(1'b1, 5'd9, 32'h99);
    settle();
    chk("sb_arrive", {31'd0, Stall}, 32'd1);
    chk_port("sb_nobypass", 1'b0, 5'd0, 32'd0);
    tick();
    md(1'b0, 5'd0, 32'd0);
    settle();
    chk_port("sb_pop", 1'b1, 5'd9, 32'h99);
    chk("sb_pop_stall", {31'd0, Stall}, 32'd1);
    tick();
    settle();
    chk("sb_cleared", {31'd0, Stall}, 32'd0);
    SrcRA = 5'd0;

    // WbRegWr with WbRW=0 does not claim the port; the buffer drains.
    md(1'b1, 5'd13, 32'h1313);
    tick();
    md(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    settle();
    chk_port("wb_r0_pop", 1'b1, 5'd13, 32'h1313);
    tick();
    settle();
    chk_port("wb_r0_idle", 1'b0, 5'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);

    // Reset mid-operation with two buffered entries and busy[4].
    IssueLong = 1'b1;
    IssueRW   = 5'd4;
    tick();
    IssueLong = 1'b0;
    IssueRW   = 5'd0;
    wb(1'b1, 5'd1, 32'h0101);
    md(1'b1, 5'd20, 32'h2020);
    tick();
    md(1'b1, 5'd21, 32'h2121);
    tick();
    md(1'b0, 5'd0, 32'd0);
    SrcRB = 5'd4;
    settle();
    chk("rmid_full", {31'd0, MdReady}, 32'd0);
    chk("rmid_stall", {31'd0, Stall}, 32'd1);
    Rst = 1'b1;
    settle();
    chk_port("rmid_rst", 1'b0, 5'd0, 32'd0);
    chk("rmid_rst_stall", {31'd0, Stall}, 32'd0);
    chk("rmid_rst_rdy", {31'd0, MdReady}, 32'd0);
    tick();
    Rst = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    settle();
    chk_port("rmid_after", 1'b0, 5'd0, 32'd0);
    chk("rmid_after_stall", {31'd0, Stall}, 32'd0);
    chk("rmid_after_rdy", {31'd0, MdReady}, 32'd1);
    tick();
    settle();
    chk_port("rmid_after2", 1'b0, 5'd0, 32'd0);
    SrcRB = 5'd0;

    // Zero register: neither issue nor result for r0 has any effect.
    IssueLong = 1'b1;
    IssueRW   = 5'd0;
    md(1'b1, 5'd0, 32'h55);
    settle();
    chk("zero_rdy", {31'd0, MdReady}, 32'd1);
    chk("zero_stall", {31'd0, Stall}, 32'd0);
    tick();
    IssueLong = 1'b0;
    md(1'b0, 5'd0, 32'd0);
    settle();
    chk_port("zero_port", 1'b0, 5'd0, 32'd0);
    chk("zero_busy", {31'd0, Stall}, 32'd0);
    tick();
    settle();
    chk_port("zero_port2", 1'b0, 5'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 DEPTH, 2, number of entries in the deferred long-latency result buffer (power of two, >= 2).
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 WbRegWr  input  1  pipeline writeback write enable.
REQ-005 WbRW  input  5  pipeline writeback destination register.
REQ-006 WbBusW  input  32  pipeline writeback data.
REQ-007 IssueLong  input  1  decode stage issues a long-latency (mult/div) op this cycle.
REQ-008 IssueRW  input  5  destination register of the issuing long-latency op.
REQ-009 SrcRA, SrcRB  input  5 each  source registers of the instruction in decode.
REQ-010 MdValid  input  1  long-latency unit presents a result.
REQ-011 MdRW  input  5  destination register of that result.
REQ-012 MdData  input  32  result data.
REQ-013 MdReady  output  1  buffer can accept a result this cycle.
REQ-014 Stall  output  1  decode must hold this cycle.
REQ-015 RegWr, RW, BusW  output  1/5/32  single register-file write port.

Function
REQ-016 The pipeline writeback path SHALL always win the write port; when WbRegWr=1 and WbRW!=0, RegWr/RW/BusW SHALL equal 1/WbRW/WbBusW combinationally in the same cycle.
REQ-017 A result SHALL be accepted into the buffer on a rising edge where MdValid=1 and MdReady=1; MdReady SHALL be 1 exactly when the buffer holds fewer than DEPTH entries.
REQ-018 When the WB path does not claim the port (WbRegWr=0 or WbRW=0) and the buffer is non-empty, the outputs SHALL present the buffer head with RegWr=1, and the head SHALL be popped at that edge.
REQ-019 With neither source active, RegWr SHALL be 0; RW and BusW SHALL be 0.
REQ-020 A result arriving into an empty buffer SHALL first appear on the port no earlier than the following cycle (one-cycle minimum latency; no bypass).
REQ-021 Simultaneous push and pop on a full buffer SHALL NOT be accepted (MdReady is 0 when full); simultaneous push and pop when not full SHALL keep occupancy unchanged.
REQ-022 A 32-bit busy scoreboard SHALL set bit IssueRW on an edge where IssueLong=1, Stall=0 and IssueRW!=0.
REQ-023 Busy bit n SHALL clear on the edge at which a buffer entry with destination n is popped; if set and clear hit the same register in one edge, set SHALL win.
REQ-024 Busy bit 0 SHALL never be set.
REQ-025 Stall SHALL be 1 when busy[SrcRA], busy[SrcRB] or (IssueLong and busy[IssueRW]) is 1; it SHALL be combinational.
REQ-026 Buffer pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-027 An MdValid result with MdRW=0 SHALL be accepted and discarded without driving RegWr.

Reset
REQ-028 While Rst=1 at an edge, the buffer SHALL become empty and all busy bits SHALL be 0; in-flight results are dropped.
REQ-029 While Rst=1, RegWr SHALL be forced to 0, MdReady to 0 and Stall to 0, overriding WB inputs.
REQ-030 Buffer data storage SHALL NOT require reset.

Structure
REQ-031 REG_ADDR_W=5, DATA_W=32 and the default buffer depth SHALL live in the shared package mips_pkg.
REQ-032 The result buffer SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty); scoreboard and port mux stay in wb_port_arbiter.

Verification
REQ-033 Idle WB only: WbRegWr=1, WbRW=5, WbBusW=0xDEADBEEF -> same cycle RegWr=1, RW=5, BusW=0xDEADBEEF.
REQ-034 Collision: MdValid with MdRW=7, data 0x11 while WB writes reg 3 for 2 cycles -> reg 3 written both cycles, reg 7 written in first cycle WB idle, busy[7] clears then.
REQ-035 Full: three back-to-back MdValid with WB continuously busy -> MdReady=0 after 2 accepts, third held, drains in order once WB idles.
REQ-036 Scoreboard: IssueLong reg 9, next decode SrcRA=9 -> Stall=1 until reg 9 result popped, Stall=0 in the following cycle.
REQ-037 Reset mid-operation: buffer holding 2 entries, busy[4]=1, assert Rst one cycle -> empty buffer, Stall=0, RegWr=0, no writes of dropped entries.
REQ-038 Zero register: IssueLong with IssueRW=0 and MdValid with MdRW=0 -> busy unchanged, RegWr never 1 for RW=0.
